// File: rtl/fetch_sequencer_if.sv
// Bundle between the fetch sequencer, instruction memory and decode.
// The master side is the sequencer; the slave side is its environment.
interface fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        halt_req;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        halted;
    logic        misaligned;

    modport master (
        output imem_addr, instr_valid, instr, instr_pc, halted, misaligned,
        input  imem_instr, redirect_valid, redirect_pc, stall, halt_req
    );

    modport slave (
        input  imem_addr, instr_valid, instr, instr_pc, halted, misaligned,
        output imem_instr, redirect_valid, redirect_pc, stall, halt_req
    );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer and instruction-stream controller: issues one fetch per cycle,
// captures the one-cycle memory response and feeds decode through a skid buffer.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  bus
);
    typedef enum logic [1:0] {RUN, HALT, TRAP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_pc_q, rsp_pc_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        halted_q, halted_d;
    logic        misaligned_q, misaligned_d;
    logic        redirect;
    logic        issue;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rsp_valid_d   = 1'b0;
        rsp_pc_d      = rsp_pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        misaligned_d  = misaligned_q;

        // A trapped sequencer ignores redirects; only reset brings it back.
        redirect = bus.redirect_valid && (state_q != TRAP);
        issue    = (state_q == RUN) && !bus.redirect_valid && !bus.stall && !bus.halt_req;

        if (redirect) begin
            pc_d          = bus.redirect_pc;
            skid_valid_d  = 1'b0;
            instr_valid_d = 1'b0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d      = TRAP;
                misaligned_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end else begin
            rsp_valid_d = issue;
            if (issue) begin
                rsp_pc_d = pc_q;
                pc_d     = pc_q + 32'd4;
            end
            if ((state_q == RUN) && bus.halt_req) begin
                state_d = HALT;
            end

            // The skid word is older than any response in flight, so it leaves first.
            if (!bus.stall) begin
                if (skid_valid_q) begin
                    instr_valid_d = 1'b1;
                    instr_d       = skid_instr_q;
                    instr_pc_d    = skid_pc_q;
                    skid_valid_d  = rsp_valid_q;
                    if (rsp_valid_q) begin
                        skid_instr_d = bus.imem_instr;
                        skid_pc_d    = rsp_pc_q;
                    end
                end else if (rsp_valid_q) begin
                    instr_valid_d = 1'b1;
                    instr_d       = bus.imem_instr;
                    instr_pc_d    = rsp_pc_q;
                end else begin
                    instr_valid_d = 1'b0;
                end
            end else if (rsp_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = bus.imem_instr;
                skid_pc_d    = rsp_pc_q;
            end
        end

        halted_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            rsp_valid_q   <= 1'b0;
            rsp_pc_q      <= 32'h0;
            instr_valid_q <= 1'b0;
            instr_q       <= 32'h0;
            instr_pc_q    <= 32'h0;
            skid_valid_q  <= 1'b0;
            skid_instr_q  <= 32'h0;
            skid_pc_q     <= 32'h0;
            halted_q      <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_pc_q      <= rsp_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            halted_q      <= halted_d;
            misaligned_q  <= misaligned_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.halted      = halted_q;
    assign bus.misaligned  = misaligned_q;
endmodule
